// File: rtl/tile_reader.sv
// Tile loader: streams one ROW_WORDS x ROWS tile from the framebuffer over an
// Avalon-MM pipelined read master into tile RAM, filling it in request order.
module tile_reader #(
    parameter int ROW_WORDS   = 16,
    parameter int ROWS        = 32,
    parameter int MAX_PENDING = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [31:0]                           addr_in,
    input  logic [15:0]                           stride_in,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(ROW_WORDS*ROWS)-1:0]     ram_addr_out,
    output logic                                  ram_wr,
    output logic [31:0]                           ram_data_out,
    output logic [31:0]                           master_address,
    output logic                                  master_read,
    input  logic [31:0]                           master_readdata,
    input  logic                                  master_readdatavalid,
    input  logic                                  master_wait_request
);

    localparam int TILE_WORDS = ROW_WORDS * ROWS;
    localparam int IDX_W      = $clog2(TILE_WORDS);
    localparam int CNT_W      = IDX_W + 1;
    localparam int PEND_W     = 4;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(TILE_WORDS - 1);
    localparam logic [IDX_W-1:0]  ROW_MASK   = IDX_W'(ROW_WORDS - 1);
    localparam logic [CNT_W-1:0]  TILE_CNT   = CNT_W'(TILE_WORDS);
    localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PENDING);
    localparam logic [31:0]       ROW_REWIND = 32'(4 * (ROW_WORDS - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [15:0]        stride_q, stride_d;
    logic [IDX_W-1:0]   issue_idx_q, issue_idx_d;
    logic [PEND_W-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]   wr_idx_q, wr_idx_d;
    logic               ram_wr_q, ram_wr_d;
    logic [IDX_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]        ram_data_q, ram_data_d;
    logic               done_q, done_d;

    logic start_ok;
    logic read_req;
    logic accept;
    logic resp;
    logic row_end;

    // A start in the done cycle is dropped: the tile is only reloaded from a clean idle.
    assign start_ok = (state_q == S_IDLE) && start && !done_q;
    assign read_req = (state_q == S_ISSUE) && (pending_q < PEND_MAX);
    assign accept   = read_req && !master_wait_request;
    // Responses with nothing outstanding, or arriving while idle, are stale leftovers.
    assign resp     = master_readdatavalid && (state_q != S_IDLE) && (pending_q != '0);
    assign row_end  = (issue_idx_q & ROW_MASK) == ROW_MASK;

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        issue_idx_d = issue_idx_q;
        pending_d   = pending_q;
        wr_idx_d    = wr_idx_q;
        ram_wr_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        done_d      = 1'b0;

        if (accept && !resp) begin
            pending_d = pending_q + PEND_W'(1);
        end else if (!accept && resp) begin
            pending_d = pending_q - PEND_W'(1);
        end

        if (resp) begin
            ram_wr_d   = 1'b1;
            ram_addr_d = wr_idx_q[IDX_W-1:0];
            ram_data_d = master_readdata;
            wr_idx_d   = wr_idx_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d     = S_ISSUE;
                    addr_d      = addr_in;
                    stride_d    = stride_in;
                    issue_idx_d = '0;
                    pending_d   = '0;
                    wr_idx_d    = '0;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    // End of row jumps back to column 0 of the next framebuffer row.
                    addr_d      = row_end ? addr_q + {16'h0000, stride_q} - ROW_REWIND
                                          : addr_q + 32'd4;
                    issue_idx_d = issue_idx_q + IDX_W'(1);
                    if (issue_idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The last write is on the RAM port this cycle, so it lands at this edge.
                if ((pending_q == '0) && (wr_idx_q == TILE_CNT)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            issue_idx_q <= '0;
            pending_q   <= '0;
            wr_idx_q    <= '0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            issue_idx_q <= issue_idx_d;
            pending_q   <= pending_d;
            wr_idx_q    <= wr_idx_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            done_q      <= done_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign master_read    = read_req;
    assign master_address = addr_q;
    assign ram_wr         = ram_wr_q;
    assign ram_addr_out   = ram_addr_q;
    assign ram_data_out   = ram_data_q;

endmodule

// File: tb/tb_tile_reader.sv
// Bench for tile_reader: an Avalon slave model with random stalls and fixed latency,
// a tile RAM capture, and a tile-address reference computed from base/stride arithmetic.
module tb_tile_reader;

    localparam int TILE = 512;
    localparam int ROWW = 16;
    localparam int MAXP = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] addr_in;
    logic [15:0] stride_in;
    logic        busy;
    logic        done;
    logic [8:0]  ram_addr_out;
    logic        ram_wr;
    logic [31:0] ram_data_out;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_wait_request;

    tile_reader dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .addr_in              (addr_in),
        .stride_in            (stride_in),
        .busy                 (busy),
        .done                 (done),
        .ram_addr_out         (ram_addr_out),
        .ram_wr               (ram_wr),
        .ram_data_out         (ram_data_out),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_wait_request  (master_wait_request)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    logic [31:0] base_m;
    logic [15:0] stride_m;

    // Word k of the tile sits at base + row*stride + col*4, modulo 2^32.
    function automatic logic [31:0] exp_addr(input int k);
        return base_m + 32'(k / ROWW) * {16'h0000, stride_m} + 32'((k % ROWW) * 4);
    endfunction

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] tb_ram [TILE];
    int          cyc = 0;
    int          lat = 1;
    int          wait_pct = 0;
    bit          mon_en = 0;
    int          acc_cnt = 0;
    int          wr_seen = 0;
    int          stale_wr = 0;
    int          done_cnt = 0;
    int          peak = 0;
    bit          held_valid = 0;
    logic [31:0] held_addr;
    logic [31:0] last_addr;
    logic [31:0] req4_addr;

    // Slave model and monitor; everything happens on the falling edge.
    always @(negedge clk) begin
        int   outstanding;
        rsp_t r;
        cyc++;
        if (ram_wr) begin
            if (mon_en) begin
                tb_ram[ram_addr_out] = ram_data_out;
                wr_seen++;
            end else begin
                stale_wr++;
            end
        end
        if (done) done_cnt++;
        outstanding = rq.size();
        if (outstanding > peak) peak = outstanding;
        if (mon_en) begin
            check("master_read_rule", 32'(master_read),
                  32'(busy && (acc_cnt < TILE) && (outstanding < MAXP)));
            if (held_valid) check("stall_addr_hold", master_address, held_addr);
        end

        master_wait_request = ($urandom_range(99) < wait_pct);
        held_valid = master_read && master_wait_request;
        held_addr  = master_address;

        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            master_readdatavalid = 1'b1;
            master_readdata      = r.data;
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = $urandom;
        end

        if (master_read && !master_wait_request) begin
            if (mon_en) begin
                check("req_addr", master_address, exp_addr(acc_cnt));
                if (acc_cnt == 4)        req4_addr = master_address;
                if (acc_cnt == TILE - 1) last_addr = master_address;
            end
            acc_cnt++;
            rq.push_back('{cyc + lat, mem_word(master_address)});
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [15:0] stride;
        int          lat;
        int          wait_pct;
        bit          mid_start;
        bit          done_probe;
        int          exp_cycles;
        int          exp_peak;
        logic [31:0] exp_last;
    } vec_t;

    task automatic run_tile(input vec_t v);
        int n;
        int bad;
        bit mid_done;
        mon_en     = 1;
        lat        = v.lat;
        wait_pct   = v.wait_pct;
        acc_cnt    = 0;
        wr_seen    = 0;
        done_cnt   = 0;
        peak       = 0;
        held_valid = 0;
        base_m     = v.addr;
        stride_m   = v.stride;
        last_addr  = 32'hFFFF_FFFF;
        req4_addr  = 32'hFFFF_FFFF;
        for (int k = 0; k < TILE; k++) tb_ram[k] = ~mem_word(exp_addr(k));

        addr_in   = v.addr;
        stride_in = v.stride;
        start     = 1'b1;
        @(posedge clk) #1;
        start    = 1'b0;
        n        = 0;
        mid_done = 0;
        while (!done && n < 6000) begin
            if (v.mid_start && !mid_done && acc_cnt >= 100) begin
                start     = 1'b1;
                addr_in   = 32'hDEAD_0000;
                stride_in = 16'h1234;
                mid_done  = 1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk) #1;
            n++;
        end
        start = 1'b0;

        check("done_seen", 32'(done), 32'd1);
        if (v.exp_cycles != 0) check("done_latency", n, v.exp_cycles);
        check("busy_low_with_done", 32'(busy), 32'd0);
        check("accept_count", acc_cnt, TILE);
        check("last_req_addr", last_addr, v.exp_last);
        if (v.exp_peak != 0) check("pending_peak", peak, v.exp_peak);
        check("pending_le_max", 32'(peak <= MAXP), 32'd1);
        if (v.addr == 32'hFFFF_FFF0) check("wrap_req4", req4_addr, 32'h0000_0000);

        if (v.done_probe) begin
            start   = 1'b1;
            addr_in = 32'h0BAD_0000;
        end
        @(posedge clk) #1;
        start = 1'b0;

        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("done_pulse_count", done_cnt, 1);
        check("ram_write_count", wr_seen, TILE);
        bad = 0;
        for (int k = 0; k < TILE; k++) begin
            if (tb_ram[k] !== mem_word(exp_addr(k))) bad++;
        end
        check("ram_contents_bad_words", bad, 0);
    endtask

    vec_t vecs[6];
    int   n;

    initial begin
        rst_n                = 1'b0;
        start                = 1'b0;
        addr_in              = '0;
        stride_in            = '0;
        master_readdata      = '0;
        master_readdatavalid = 1'b0;
        master_wait_request  = 1'b0;

        //          addr          stride    lat wait mid probe cycles peak last
        vecs[0] = '{32'h1000_0000, 16'h0800, 3,  0,  0,  0,   516,   3, 32'h1000_F83C};
        vecs[1] = '{32'h2000_0040, 16'h0100, 2,  50, 1,  0,   0,     0, 32'h2000_1F7C};
        vecs[2] = '{32'h0000_0000, 16'h0040, 20, 0,  0,  0,   0,     8, 32'h0000_07FC};
        vecs[3] = '{32'hFFFF_FFF0, 16'h0040, 1,  0,  0,  1,   514,   1, 32'h0000_07EC};
        vecs[4] = '{32'h8000_0000, 16'hFFFF, 7,  0,  0,  0,   520,   7, 32'h801F_001D};
        vecs[5] = '{32'h0000_1000, 16'h0200, 4,  30, 0,  0,   0,     0, 32'h0000_4E3C};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_master_read", 32'(master_read), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_master_address", master_address, 32'd0);
        check("rst_ram_addr", 32'(ram_addr_out), 32'd0);
        check("rst_ram_data", ram_data_out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk) #1;

        for (int i = 0; i < 6; i++) run_tile(vecs[i]);

        // Abort mid-tile with reset, then let the stale responses arrive while idle.
        mon_en   = 1;
        lat      = 5;
        wait_pct = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        stale_wr = 0;
        base_m   = 32'h3000_0000;
        stride_m = 16'h0400;
        addr_in  = base_m;
        stride_in = stride_m;
        start    = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        n = 0;
        while (acc_cnt < 200 && n < 1000) begin
            @(posedge clk) #1;
            n++;
        end
        check("abort_reached_req200", 32'(acc_cnt >= 200), 32'd1);
        rst_n  = 1'b0;
        mon_en = 0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_master_read", 32'(master_read), 32'd0);
        check("abort_ram_wr", 32'(ram_wr), 32'd0);
        check("abort_master_address", master_address, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("stale_rdv_writes", stale_wr, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_stays_idle", 32'(busy), 32'd0);

        run_tile(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
